// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, FSM state encoding and the forwarding compare helper.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    // MEM result wins over WB result; $0 is hard-wired zero and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_regwr,
        input logic [4:0] mem_rw,
        input logic       wb_regwr,
        input logic [4:0] wb_rw,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (mem_regwr && (mem_rw != 5'd0) && (mem_rw == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwr && (wb_rw != 5'd0) && (wb_rw == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard bus between the pipeline datapath (master) and the hazard
// controller (slave): stage register/destination info in, pipeline-register
// stall/flush/bubble controls and forwarding selects out.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] exe_rs;
    logic [4:0] exe_rt;
    logic [4:0] exe_rw;
    logic       exe_regwr;
    logic       exe_memtoreg;
    logic       exe_br_taken;
    logic [4:0] mem_rw;
    logic       mem_regwr;
    logic [4:0] wb_rw;
    logic       wb_regwr;
    logic       mem_req;
    logic       mem_ack;

    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_exe_stall;
    logic       id_exe_bubble;
    logic       exe_mem_stall;
    logic       mem_wb_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mem_err;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output exe_rs, exe_rt, exe_rw, exe_regwr, exe_memtoreg, exe_br_taken,
        output mem_rw, mem_regwr, wb_rw, wb_regwr, mem_req, mem_ack,
        input  pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_bubble,
        input  exe_mem_stall, mem_wb_bubble, fwd_a, fwd_b, mem_err
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  exe_rs, exe_rt, exe_rw, exe_regwr, exe_memtoreg, exe_br_taken,
        input  mem_rw, mem_regwr, wb_rw, wb_regwr, mem_req, mem_ack,
        output pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_bubble,
        output exe_mem_stall, mem_wb_bubble, fwd_a, fwd_b, mem_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EXE-stage operand forwarding compare for both ALU operands.
// Purely combinational.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       mem_regwr,
    input  logic [4:0] mem_rw,
    input  logic       wb_regwr,
    input  logic [4:0] wb_rw,
    input  logic [4:0] exe_rs,
    input  logic [4:0] exe_rt,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // Select the youngest in-flight producer of each EXE source register.
    always_comb begin
        fwd_a = fwd_sel(mem_regwr, mem_rw, wb_regwr, wb_rw, exe_rs);
        fwd_b = fwd_sel(mem_regwr, mem_rw, wb_regwr, wb_rw, exe_rt);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Resolves data-memory freezes, taken-branch flushes and load-use stalls
// (in that priority order) and drives the EXE forwarding selects.
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit event counters.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_RUN      | pipeline flowing, no memory access outstanding
// ST_MEM_WAIT | data memory access pending; freeze counter is running
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 CLK,
    input  logic                 reset,
    pipe_hazard_ctrl_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          cnt_loaduse,
    output logic [31:0]          cnt_brflush,
    output logic [31:0]          cnt_memwait
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    logic             freeze;
    logic             lu_match;
    logic             br_win;
    logic             lu_win;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    pipe_hazard_ctrl_fwd_unit u_fwd_unit (
        .mem_regwr (hz.mem_regwr),
        .mem_rw    (hz.mem_rw),
        .wb_regwr  (hz.wb_regwr),
        .wb_rw     (hz.wb_rw),
        .exe_rs    (hz.exe_rs),
        .exe_rt    (hz.exe_rt),
        .fwd_a     (fwd_a_raw),
        .fwd_b     (fwd_b_raw)
    );

    // Hazard detection and priority: freeze > taken branch > load-use.
    always_comb begin
        freeze   = hz.mem_req & ~hz.mem_ack;
        lu_match = hz.exe_memtoreg & hz.exe_regwr & (hz.exe_rw != 5'd0) &
                   ((hz.id_use_rs & (hz.id_rs == hz.exe_rw)) |
                    (hz.id_use_rt & (hz.id_rt == hz.exe_rw)));
        br_win   = ~freeze & hz.exe_br_taken;
        lu_win   = ~freeze & ~hz.exe_br_taken & lu_match;
    end

    // Pipeline controls; everything is forced quiet while reset is held so a
    // reset during a freeze releases the pipeline without waiting for CLK.
    always_comb begin
        hz.pc_stall      = reset & (freeze | lu_win);
        hz.if_id_stall   = reset & (freeze | lu_win);
        hz.if_id_flush   = reset & br_win;
        hz.id_exe_stall  = reset & freeze;
        hz.id_exe_bubble = reset & (br_win | lu_win);
        hz.exe_mem_stall = reset & freeze;
        hz.mem_wb_bubble = reset & freeze;
        hz.fwd_a         = reset ? fwd_a_raw : FWD_REG;
        hz.fwd_b         = reset ? fwd_b_raw : FWD_REG;
        hz.mem_err       = mem_err_q;
    end

    // Next state: count consecutive freeze cycles of one access, saturating
    // at the timeout; the timeout flag is sticky until reset.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (freeze) begin
                    if (cnt_q != TIMEOUT_C) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        if (cnt_d == TIMEOUT_C) begin
            mem_err_d = 1'b1;
        end
    end

    // FSM, freeze counter and timeout flag registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_loaduse_q, cnt_loaduse_d;
    logic [31:0] cnt_brflush_q, cnt_brflush_d;
    logic [31:0] cnt_memwait_q, cnt_memwait_d;

    // Event counters bump only for the condition that won priority this cycle.
    always_comb begin
        cnt_loaduse_d = cnt_loaduse_q;
        cnt_brflush_d = cnt_brflush_q;
        cnt_memwait_d = cnt_memwait_q;
        if (lu_win) cnt_loaduse_d = cnt_loaduse_q + 32'd1;
        if (br_win) cnt_brflush_d = cnt_brflush_q + 32'd1;
        if (freeze) cnt_memwait_d = cnt_memwait_q + 32'd1;
    end

    // Wrapping event counter registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_loaduse_q <= '0;
            cnt_brflush_q <= '0;
            cnt_memwait_q <= '0;
        end else begin
            cnt_loaduse_q <= cnt_loaduse_d;
            cnt_brflush_q <= cnt_brflush_d;
            cnt_memwait_q <= cnt_memwait_d;
        end
    end

    assign cnt_loaduse = cnt_loaduse_q;
    assign cnt_brflush = cnt_brflush_q;
    assign cnt_memwait = cnt_memwait_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline. It generates the stall and bubble controls for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers, and the EXE-stage operand forwarding selects. It resolves load-use hazards, taken-branch flushes and data-memory wait states. A small FSM tracks multi-cycle memory freezes and flags timeouts.

Parameters:
MEM_TIMEOUT, 16, max consecutive freeze cycles on one memory access before mem_err sets.
CNT_W, 5, width of the freeze cycle counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
id_rs  in  5  rs field of the ID instruction
id_rt  in  5  rt field of the ID instruction
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
exe_rs  in  5  rs of the EXE instruction
exe_rt  in  5  rt of the EXE instruction
exe_rw  in  5  destination of the EXE instruction (after RegDst)
exe_regwr  in  1  EXE instruction writes the register file
exe_memtoreg  in  1  EXE instruction is a load
exe_br_taken  in  1  branch resolved taken in EXE
mem_rw  in  5  destination in the MEM stage
mem_regwr  in  1  MEM stage writes the register file
wb_rw  in  5  destination in the WB stage
wb_regwr  in  1  WB stage writes the register file
mem_req  in  1  MEM stage is accessing data memory
mem_ack  in  1  data memory completes the access this cycle
pc_stall  out  1  hold the PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to NOP
id_exe_stall  out  1  hold ID/EXE (drives its stall input)
id_exe_bubble  out  1  force zero controls into ID/EXE
exe_mem_stall  out  1  hold EXE/MEM
mem_wb_bubble  out  1  insert NOP into MEM/WB
fwd_a  out  2  ALU A select: 00 BusA, 01 MEM result, 10 WB result
fwd_b  out  2  ALU B select, same encoding
mem_err  out  1  sticky timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT. Reset (reset=0, asynchronous) gives state=RUN, counter=0, mem_err=0. All stall, flush and bubble outputs are then 0 and fwd_a=fwd_b=00.
- Freeze condition: mem_req & ~mem_ack, in any state.
  - Outputs in the same cycle: pc_stall, if_id_stall, id_exe_stall and exe_mem_stall = 1; mem_wb_bubble = 1.
  - Branch and load-use outputs are suppressed while frozen. Freeze has highest priority.
- RUN -> MEM_WAIT when frozen. MEM_WAIT -> RUN on the first cycle with mem_ack=1 or mem_req=0. On that cycle no freeze outputs are asserted.
- Counter: increments each MEM_WAIT cycle and saturates. When it reaches MEM_TIMEOUT, mem_err is set. mem_err is cleared only by reset. The counter clears on return to RUN.
- Taken branch (exe_br_taken=1, not frozen): if_id_flush=1 and id_exe_bubble=1 for exactly that cycle. Load-use is ignored in that cycle because the ID instruction is being squashed.
- Load-use (not frozen, no taken branch): asserted when all of the following hold:
  - exe_memtoreg=1, exe_regwr=1 and exe_rw != 0;
  - (id_use_rs and id_rs == exe_rw) or (id_use_rt and id_rt == exe_rw).
  - Response: pc_stall=1, if_id_stall=1, id_exe_bubble=1 for exactly one cycle; id_exe_stall=0.
- Forwarding (combinational, per operand, shown for fwd_a using exe_rs):
  - 01 if mem_regwr, mem_rw != 0 and mem_rw == exe_rs;
  - else 10 if wb_regwr, wb_rw != 0 and wb_rw == exe_rs;
  - else 00.
  - MEM takes priority over WB. Register 0 never forwards. fwd_b is identical using exe_rt.
- Stall and flush outputs are combinational from state and inputs: 0-cycle latency. Only state, counter and mem_err are registered.
- Reset mid-freeze: state returns to RUN immediately, independent of CLK.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three 32-bit wrapping counters, cnt_loaduse, cnt_brflush and cnt_memwait, as extra outputs. Each increments on cycles where the corresponding condition wins priority. All reset to 0.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Shared package: forwarding select constants (FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and the FSM state encoding (ST_RUN, ST_MEM_WAIT).
- One natural sub-module, fwd_unit: the pure combinational forwarding compare, instantiated once and producing both fwd_a and fwd_b.

Test Plan:
- Load-use: EXE lw to $8; ID add reads rs=$8 -> one cycle with pc_stall=if_id_stall=id_exe_bubble=1; next cycle (load now in MEM, mem_rw=8, mem_regwr=1) fwd_a=01.
- Taken branch coincident with a load-use match -> if_id_flush=1, id_exe_bubble=1, pc_stall=0 for one cycle.
- mem_req=1 with mem_ack low for 3 cycles -> 3 cycles of full freeze, state MEM_WAIT; mem_ack=1 -> freeze drops that cycle, state returns to RUN, mem_err=0.
- mem_ack held low for 16 cycles with MEM_TIMEOUT=16 -> mem_err=1 and stays set after the access ends; only reset clears it.
- mem_rw=wb_rw=5, both writing, exe_rs=5 -> fwd_a=01; mem_rw=0 with exe_rt=0 -> fwd_b=00.
- reset asserted during MEM_WAIT -> all outputs 0 immediately, state=RUN, before the next CLK edge.
